// File: rtl/ysyx_24100012_imem_arb.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_imem_arb
//
// Two-requester arbiter and sequencer in front of the combinational
// instruction ROM. Requester 0 is the IFU fetch port and requester 1 is the
// LSU read-only port. One request is granted at a time with round-robin
// priority. The ROM word is captured into a response register, so the
// response appears one cycle after the request handshake. Misaligned and
// out-of-window addresses return an error with a zero data word.
//
// Optional feature: define YSYX_24100012_IMEM_ARB_PERF_EN to add the
// free-running performance counters perf_m0_grants, perf_m1_grants and
// perf_conflicts. These counters wrap to zero after 32'hFFFFFFFF.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   m0_req_*            IFU request channel (valid/ready/addr)
//   m0_resp_*           IFU response channel (valid/ready/data/err)
//   m1_req_*, m1_resp_* LSU channels, same meaning as m0
//   rom_addr            byte address driven to the ROM
//   rom_data            combinational ROM word for rom_addr
//   perf_*              performance counters (only with the macro above)
// ----------------------------------------------------------------------------
module ysyx_24100012_imem_arb #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h80000000,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 32'h00001000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    output logic                  m0_resp_valid,
    input  logic                  m0_resp_ready,
    output logic [DATA_WIDTH-1:0] m0_resp_data,
    output logic                  m0_resp_err,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    output logic                  m1_resp_valid,
    input  logic                  m1_resp_ready,
    output logic [DATA_WIDTH-1:0] m1_resp_data,
    output logic                  m1_resp_err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
   ,output logic [31:0]           perf_m0_grants,
    output logic [31:0]           perf_m1_grants,
    output logic [31:0]           perf_conflicts
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    rr_q;
    logic                    owner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    resp_err_q;
    logic                    m0_resp_valid_q;
    logic                    m1_resp_valid_q;

    logic                    win;
    logic                    grant0;
    logic                    grant1;
    logic                    handshake;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_err;
    logic [DATA_WIDTH-1:0]   resp_data_d;
    logic                    owner_resp_ready;
    logic [ADDR_WIDTH:0]     addr_ext;
    logic [ADDR_WIDTH:0]     base_ext;
    logic [ADDR_WIDTH:0]     limit_ext;

    // Winner selection: on contention the round-robin pointer decides,
    // otherwise the single active requester wins. With no request the
    // winner defaults to m0 so rom_addr follows m0_req_addr.
    always_comb begin
        win = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            win = rr_q;
        end else if (m1_req_valid) begin
            win = 1'b1;
        end
    end

    // Grants only exist in IDLE and never while reset is held.
    assign grant0    = rst_n && (state_q == IDLE) && m0_req_valid && !win;
    assign grant1    = rst_n && (state_q == IDLE) && m1_req_valid &&  win;
    assign handshake = grant0 || grant1;

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;

    assign req_addr = win ? m1_req_addr : m0_req_addr;
    assign rom_addr = (state_q == IDLE) ? req_addr : addr_q;

    // Range check is one bit wider than the address so the window end
    // BASE_ADDR+SIZE_BYTES cannot wrap around to a small value.
    assign addr_ext  = {1'b0, req_addr};
    assign base_ext  = {1'b0, BASE_ADDR};
    assign limit_ext = base_ext + {1'b0, SIZE_BYTES};

    assign req_err = (req_addr[1:0] != 2'b00)
                   || (addr_ext <  base_ext)
                   || (addr_ext >= limit_ext);

    assign resp_data_d      = req_err ? '0 : rom_data;
    assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;

    // Request/response sequencer: IDLE captures the granted request and
    // ROM word, RESP holds them until the owner accepts, then hands the
    // round-robin priority to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_q            <= 1'b0;
            owner_q         <= 1'b0;
            addr_q          <= '0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            m0_resp_valid_q <= 1'b0;
            m1_resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        owner_q         <= win;
                        addr_q          <= req_addr;
                        resp_data_q     <= resp_data_d;
                        resp_err_q      <= req_err;
                        m0_resp_valid_q <= grant0;
                        m1_resp_valid_q <= grant1;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        rr_q            <= ~owner_q;
                        m0_resp_valid_q <= 1'b0;
                        m1_resp_valid_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_resp_valid = m0_resp_valid_q;
    assign m1_resp_valid = m1_resp_valid_q;

    // Only the owner of the captured word sees it; the other port reads 0.
    assign m0_resp_data = owner_q ? '0 : resp_data_q;
    assign m0_resp_err  = owner_q ? 1'b0 : resp_err_q;
    assign m1_resp_data = owner_q ? resp_data_q : '0;
    assign m1_resp_err  = owner_q ? resp_err_q : 1'b0;

`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
    logic [31:0] perf_m0_grants_q;
    logic [31:0] perf_m1_grants_q;
    logic [31:0] perf_conflicts_q;
    logic        conflict;

    assign conflict = (state_q == IDLE) && m0_req_valid && m1_req_valid;

    // Event counters; natural 32-bit overflow provides the wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_m0_grants_q <= '0;
            perf_m1_grants_q <= '0;
            perf_conflicts_q <= '0;
        end else begin
            if (grant0) begin
                perf_m0_grants_q <= perf_m0_grants_q + 32'd1;
            end
            if (grant1) begin
                perf_m1_grants_q <= perf_m1_grants_q + 32'd1;
            end
            if (conflict) begin
                perf_conflicts_q <= perf_conflicts_q + 32'd1;
            end
        end
    end

    assign perf_m0_grants = perf_m0_grants_q;
    assign perf_m1_grants = perf_m1_grants_q;
    assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_ysyx_24100012_imem_arb.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24100012_imem_arb. A behavioural ROM answers rom_addr.
// Every request handshake pushes the expected response (port, data, error)
// into a queue, and every response handshake pops and compares it. The
// scenario tasks additionally check grant timing, stability and reset.
// ----------------------------------------------------------------------------
module tb_ysyx_24100012_imem_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid;
    logic        m0_req_ready;
    logic [31:0] m0_req_addr;
    logic        m0_resp_valid;
    logic        m0_resp_ready;
    logic [31:0] m0_resp_data;
    logic        m0_resp_err;
    logic        m1_req_valid;
    logic        m1_req_ready;
    logic [31:0] m1_req_addr;
    logic        m1_resp_valid;
    logic        m1_resp_ready;
    logic [31:0] m1_resp_data;
    logic        m1_resp_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
    logic [31:0] perf_m0_grants;
    logic [31:0] perf_m1_grants;
    logic [31:0] perf_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ysyx_24100012_imem_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_addr  (m0_req_addr),
        .m0_resp_valid(m0_resp_valid),
        .m0_resp_ready(m0_resp_ready),
        .m0_resp_data (m0_resp_data),
        .m0_resp_err  (m0_resp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_addr  (m1_req_addr),
        .m1_resp_valid(m1_resp_valid),
        .m1_resp_ready(m1_resp_ready),
        .m1_resp_data (m1_resp_data),
        .m1_resp_err  (m1_resp_err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
       ,.perf_m0_grants(perf_m0_grants),
        .perf_m1_grants(perf_m1_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM: two fixed words, everything else a pattern of the address.
    function automatic logic [31:0] rom_model(input logic [31:0] a);
        case (a)
            32'h80000000: rom_model = 32'h00100513;
            32'h80000018: rom_model = 32'h00108073;
            default:      rom_model = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign rom_data = rom_model(rom_addr);

    function automatic exp_t make_exp(input int port, input logic [31:0] a);
        exp_t        e;
        logic [63:0] wide;
        wide   = {32'h0, a};
        e.port = port;
        e.err  = (a[1:0] != 2'b00) || (wide < 64'h80000000) || (wide >= 64'h80001000);
        e.data = e.err ? 32'h0 : rom_model(a);
        return e;
    endfunction

    // Scoreboard monitor, sampling mid-cycle after the scenario tasks drive.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (m0_resp_valid && m0_resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_m0_unexpected: got data %h err %b, expected no response", m0_resp_data, m0_resp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.port !== 0 || m0_resp_data !== mon_e.data || m0_resp_err !== mon_e.err) begin
                        errors++;
                        $display("[TB] FAIL sb_m0: got port 0 data %h err %b, expected port %0d data %h err %b", m0_resp_data, m0_resp_err, mon_e.port, mon_e.data, mon_e.err);
                    end
                end
            end
            if (m1_resp_valid && m1_resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_m1_unexpected: got data %h err %b, expected no response", m1_resp_data, m1_resp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.port !== 1 || m1_resp_data !== mon_e.data || m1_resp_err !== mon_e.err) begin
                        errors++;
                        $display("[TB] FAIL sb_m1: got port 1 data %h err %b, expected port %0d data %h err %b", m1_resp_data, m1_resp_err, mon_e.port, mon_e.data, mon_e.err);
                    end
                end
            end
            if (m0_req_valid && m0_req_ready) exp_q.push_back(make_exp(0, m0_req_addr));
            if (m1_req_valid && m1_req_ready) exp_q.push_back(make_exp(1, m1_req_addr));
        end
    end

    task automatic applyStimulus_idle();
        m0_req_valid  = 1'b0;
        m0_req_addr   = 32'h0;
        m0_resp_ready = 1'b0;
        m1_req_valid  = 1'b0;
        m1_req_addr   = 32'h0;
        m1_resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        applyStimulus_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        applyStimulus_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_resp_valid: got %b%b, expected 00", m0_resp_valid, m1_resp_valid);
        end
        checks++;
        if (m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_req_ready: got %b%b, expected 00", m0_req_ready, m1_req_ready);
        end
        checks++;
        if (m0_resp_data !== 32'h0 || m1_resp_data !== 32'h0 || m0_resp_err !== 1'b0 || m1_resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_resp_data: got %h/%h err %b%b, expected 0", m0_resp_data, m1_resp_data, m0_resp_err, m1_resp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000000; m0_resp_ready = 1'b0;
        #2;
        checks++;
        if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL single_grant: got ready %b%b, expected 10", m0_req_ready, m1_req_ready);
        end
        checks++;
        if (rom_addr !== 32'h80000000) begin
            errors++; $display("[TB] FAIL single_rom_addr: got %h, expected 80000000", rom_addr);
        end
        @(negedge clk);
        m0_req_valid = 1'b0; m0_req_addr = 32'h0;
        #2;
        checks++;
        if (m0_resp_valid !== 1'b1 || m0_resp_data !== 32'h00100513 || m0_resp_err !== 1'b0 || m1_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_resp: got valid %b data %h err %b, expected 1 00100513 0", m0_resp_valid, m0_resp_data, m0_resp_err);
        end
        checks++;
        if (rom_addr !== 32'h80000000) begin
            errors++; $display("[TB] FAIL single_rom_addr_hold: got %h, expected 80000000", rom_addr);
        end
        repeat (2) begin
            @(negedge clk);
            #2;
            checks++;
            if (m0_resp_valid !== 1'b1 || m0_resp_data !== 32'h00100513) begin
                errors++; $display("[TB] FAIL single_hold: got valid %b data %h, expected 1 00100513", m0_resp_valid, m0_resp_data);
            end
        end
        @(negedge clk);
        m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_resp_ready = 1'b0;
        #2;
        checks++;
        if (m0_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_drop: got valid %b, expected 0", m0_resp_valid);
        end
    endtask

    task automatic test_conflict();
        logic exp_win;
        do_reset();
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000004;
        m1_req_valid = 1'b1; m1_req_addr = 32'h80000018;
        m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        #2;
        checks++;
        if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL conflict_first: got ready %b%b, expected 10", m0_req_ready, m1_req_ready);
        end
        @(negedge clk);
        m0_req_valid = 1'b0;
        #2;
        checks++;
        if (m0_resp_valid !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL conflict_m0_resp: got valid %b m1 ready %b, expected 1 0", m0_resp_valid, m1_req_ready);
        end
        @(negedge clk);
        #2;
        checks++;
        if (m1_req_ready !== 1'b1 || m0_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL conflict_m1_grant: got m1 ready %b m0 valid %b, expected 1 0", m1_req_ready, m0_resp_valid);
        end
        @(negedge clk);
        m1_req_valid = 1'b0;
        #2;
        checks++;
        if (m1_resp_valid !== 1'b1 || m1_resp_data !== 32'h00108073 || m0_resp_data !== 32'h0) begin
            errors++; $display("[TB] FAIL conflict_m1_resp: got valid %b data %h m0 data %h, expected 1 00108073 0", m1_resp_valid, m1_resp_data, m0_resp_data);
        end
        // Continuous contention: grants must alternate starting with m0.
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000100;
        m1_req_valid = 1'b1; m1_req_addr = 32'h80000200;
        for (int i = 0; i < 6; i++) begin
            exp_win = i[0];
            #2;
            checks++;
            if (m0_req_ready !== !exp_win || m1_req_ready !== exp_win) begin
                errors++; $display("[TB] FAIL rr_alternate_%0d: got ready %b%b, expected winner m%0d", i, m0_req_ready, m1_req_ready, exp_win);
            end
            @(negedge clk);
            if (i == 5) begin
                m0_req_valid = 1'b0; m1_req_valid = 1'b0;
            end
            #2;
            checks++;
            if (m0_resp_valid !== !exp_win || m1_resp_valid !== exp_win || m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL rr_resp_%0d: got valid %b%b ready %b%b, expected winner m%0d", i, m0_resp_valid, m1_resp_valid, m0_req_ready, m1_req_ready, exp_win);
            end
            @(negedge clk);
        end
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        errs  [4];
        exp_t        e;
        addrs[0] = 32'h80000002; errs[0] = 1'b1;
        addrs[1] = 32'h7FFFFFFC; errs[1] = 1'b1;
        addrs[2] = 32'h80001000; errs[2] = 1'b1;
        addrs[3] = 32'h80000FFC; errs[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = make_exp(1, addrs[i]);
            @(negedge clk);
            m1_req_valid = 1'b1; m1_req_addr = addrs[i]; m1_resp_ready = 1'b1;
            #2;
            checks++;
            if (m1_req_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL err_grant_%0d: got ready %b, expected 1", i, m1_req_ready);
            end
            @(negedge clk);
            m1_req_valid = 1'b0;
            #2;
            checks++;
            if (m1_resp_valid !== 1'b1 || m1_resp_err !== errs[i] || m1_resp_data !== (errs[i] ? 32'h0 : e.data)) begin
                errors++; $display("[TB] FAIL err_resp_%h: got valid %b err %b data %h, expected 1 %b %h", addrs[i], m1_resp_valid, m1_resp_err, m1_resp_data, errs[i], errs[i] ? 32'h0 : e.data);
            end
        end
        @(negedge clk);
        m1_resp_ready = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000008; m0_resp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_req_addr = 32'h8000000C; m1_resp_ready = 1'b1;
        #2;
        checks++;
        if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_grant: got ready %b%b, expected 10", m0_req_ready, m1_req_ready);
        end
        @(negedge clk);
        m0_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            checks++;
            if (m1_req_ready !== 1'b0 || m0_resp_valid !== 1'b1 || m0_resp_data !== rom_model(32'h80000008)) begin
                errors++; $display("[TB] FAIL hold_cycle_%0d: got m1 ready %b m0 valid %b data %h, expected 0 1 %h", k, m1_req_ready, m0_resp_valid, m0_resp_data, rom_model(32'h80000008));
            end
            @(negedge clk);
        end
        m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_resp_ready = 1'b0;
        #2;
        checks++;
        if (m1_req_ready !== 1'b1 || m0_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_m1_after: got m1 ready %b m0 valid %b, expected 1 0", m1_req_ready, m0_resp_valid);
        end
        @(negedge clk);
        m1_req_valid = 1'b0;
        #2;
        checks++;
        if (m1_resp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_m1_resp: got valid %b, expected 1", m1_resp_valid);
        end
        @(negedge clk);
        m1_resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        // Serve m0 once so the pointer favours m1 before the reset.
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000010; m0_resp_ready = 1'b1;
        @(negedge clk);
        m0_req_valid = 1'b0;
        @(negedge clk);
        m0_resp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_req_addr = 32'h80000014; m1_resp_ready = 1'b0;
        @(negedge clk);
        m1_req_valid = 1'b0;
        #2;
        checks++;
        if (m1_resp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_pre: got valid %b, expected 1", m1_resp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m1_resp_valid !== 1'b0 || m1_resp_data !== 32'h0) begin
            errors++; $display("[TB] FAIL midreset_async: got valid %b data %h, expected 0 0", m1_resp_valid, m1_resp_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        m1_resp_ready = 1'b1; m0_resp_ready = 1'b1;
        #2;
        checks++;
        if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_no_resp: got valid %b%b, expected 00", m0_resp_valid, m1_resp_valid);
        end
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000020;
        m1_req_valid = 1'b1; m1_req_addr = 32'h80000024;
        #2;
        checks++;
        if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_priority: got ready %b%b, expected 10", m0_req_ready, m1_req_ready);
        end
        @(negedge clk);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        @(negedge clk);
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    endtask

`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        @(negedge clk);
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000030;
        m1_req_valid = 1'b1; m1_req_addr = 32'h80000034;
        m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin m0_req_valid = 1'b1; m0_req_addr = 32'h80000040; end
            else       begin m1_req_valid = 1'b1; m1_req_addr = 32'h80000044; end
            @(negedge clk);
            m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        end
        @(negedge clk);
        #2;
        checks++;
        if (perf_m0_grants !== 32'd3 || perf_m1_grants !== 32'd2 || perf_conflicts !== 32'd2) begin
            errors++; $display("[TB] FAIL perf_counts: got %0d %0d %0d, expected 3 2 2", perf_m0_grants, perf_m1_grants, perf_conflicts);
        end
        @(negedge clk);
        dut.perf_m0_grants_q = 32'hFFFFFFFF;
        m0_req_valid = 1'b1; m0_req_addr = 32'h80000048;
        @(negedge clk);
        m0_req_valid = 1'b0;
        #2;
        checks++;
        if (perf_m0_grants !== 32'h0) begin
            errors++; $display("[TB] FAIL perf_wrap: got %h, expected 00000000", perf_m0_grants);
        end
        @(negedge clk);
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_errors();
        test_hold();
        test_reset_mid_resp();
`ifdef YSYX_24100012_IMEM_ARB_PERF_EN
        test_perf();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("[TB] FAIL sb_drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_imem_arb.md
Name: ysyx_24100012_imem_arb

Overview:
- Two-requester arbiter and sequencer in front of the combinational instruction ROM (`ysyx_24100012_rom`).
- Requester 0 is the IFU fetch port; requester 1 is the LSU read-only port.
- Grants one requester at a time with round-robin priority and samples the ROM word into a response register (1-cycle latency).
- Flags misaligned and out-of-range addresses as errors.

Parameters:
- ADDR_WIDTH, 32, address width of requests and ROM port
- DATA_WIDTH, 32, ROM word width
- BASE_ADDR, 32'h80000000, first valid ROM byte address
- SIZE_BYTES, 32'h00001000, ROM window size in bytes; valid range is [BASE_ADDR, BASE_ADDR+SIZE_BYTES)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req_valid  in  1  IFU request valid
- m0_req_ready  out  1  IFU request accepted
- m0_req_addr  in  ADDR_WIDTH  IFU byte address
- m0_resp_valid  out  1  IFU response valid
- m0_resp_ready  in  1  IFU takes response
- m0_resp_data  out  DATA_WIDTH  IFU response word
- m0_resp_err  out  1  IFU access error
- m1_req_valid, m1_req_ready, m1_req_addr, m1_resp_valid, m1_resp_ready, m1_resp_data, m1_resp_err: same as m0_* for the LSU
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_data  in  DATA_WIDTH  combinational ROM word

Behaviour:
- Reset (async, rst_n=0), all cleared immediately:
  - state=IDLE, rr_ptr=0 (m0 priority), owner=0.
  - resp_data=0, resp_err=0.
  - All *_req_ready and *_resp_valid = 0.
- FSM states: IDLE, RESP.
- IDLE, winner selection:
  - Both valid: the requester equal to rr_ptr wins.
  - One valid: that requester wins.
- IDLE, outputs:
  - Winner's req_ready=1 combinationally; loser's req_ready=0.
  - rom_addr = winner addr; if no request, rom_addr = m0_req_addr.
- IDLE, on handshake (valid & ready):
  - Register owner=winner.
  - err = (addr[1:0]!=0) | (addr<BASE_ADDR) | (addr>=BASE_ADDR+SIZE_BYTES).
  - Range comparison uses ADDR_WIDTH+1 bits, so BASE_ADDR+SIZE_BYTES never wraps.
  - resp_data = err ? 0 : rom_data.
  - Go to RESP.
- RESP, outputs:
  - Owner's resp_valid=1; the other resp_valid=0.
  - Both req_ready=0.
  - rom_addr holds the latched request address.
  - resp_data/resp_err are stable until accepted.
- RESP, on owner resp_ready=1:
  - Go to IDLE; rr_ptr = ~owner.
  - resp_valid drops on the next cycle.
  - The new grant starts in that IDLE cycle.
- Throughput and latency:
  - Latency: request handshake at cycle N, resp_valid at N+1.
  - Back-to-back rate is 1 transaction per 2 cycles minimum.
- Non-owner resp_*_data/err outputs are 0.
- Requesters hold addr stable while valid and not ready; the arbiter does not check this.
- A requester that drops valid before ready loses nothing (no grant was recorded).
- Simultaneous requests with rr_ptr=1: m1 is served first, then m0.
- Reset mid-RESP: the pending response is discarded, resp_valid falls asynchronously, and no response is ever delivered for it.
- resp_ready asserted while resp_valid=0 is ignored.

Optional Feature:
- Macro: YSYX_24100012_IMEM_ARB_PERF_EN.
- When defined, adds outputs perf_m0_grants [31:0], perf_m1_grants [31:0] and perf_conflicts [31:0]:
  - perf_mN_grants increment on each request handshake of requester N.
  - perf_conflicts increments on each IDLE cycle where both req_valid=1.
  - All three are cleared by rst_n and wrap from 32'hFFFFFFFF to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then m0 requests 32'h80000000 with the ROM returning 32'h00100513 → m0_req_ready=1 the same cycle; next cycle m0_resp_valid=1, data=32'h00100513, err=0; held until resp_ready.
- m0 and m1 valid simultaneously after reset (m0 addr 32'h80000004, m1 addr 32'h80000018) → m0 served first; after m0 response accepted, m1 granted and receives 32'h00108073; rr_ptr alternates on repeated conflicts.
- m1 requests 32'h80000002 → m1_resp_err=1, data=0; m1 requests 32'h7FFFFFFC and 32'h80001000 → err=1; 32'h80000FFC → err=0.
- Hold m0_resp_ready=0 for 5 cycles while m1_req_valid=1 → m1_req_ready stays 0 and m0 response data stays stable; m1 is granted in the IDLE cycle after m0 accepts.
- Assert rst_n=0 in RESP → resp_valid falls without a clock edge; after release, the state is IDLE and m0 has priority.
- With YSYX_24100012_IMEM_ARB_PERF_EN: 3 m0 grants, 2 m1 grants and 2 conflict cycles → counters read 3, 2, 2; preloading a counter to 32'hFFFFFFFF and adding one grant → 0.
